ofifo_psum: RTL and testbench

- Output FIFO stage placed directly downstream of the gated MAC column array.
- Each column of the MAC array produces psums on its own schedule, and each column writes into its own FIFO lane.
- The read side pops complete rows in lockstep. A row is one psum from every column. Rows feed the SFP/accumulate stage or the memory writeback path.
- Per-column stagger is absorbed here. Overflow is detected and reported, not silently lost.

---
 rtl/ofifo_psum_pkg.sv | 13 +
 rtl/ofifo_psum_lane.sv | 59 +++++
 rtl/ofifo_psum.sv | 81 ++++++++
 tb/tb_ofifo_psum.sv | 204 ++++++++++++++++++++
 4 files changed

// File: rtl/ofifo_psum_pkg.sv
// Shared constants and lane-slicing helper for the output psum FIFO.
package ofifo_psum_pkg;

  localparam int PSUM_BW = 22;
  localparam int COL     = 8;
  localparam int DEPTH   = 64;

  // LSB position of a lane inside a packed col*bw bus
  function automatic int lane_lsb(input int lane, input int bw);
    return lane * bw;
  endfunction

endpackage

// File: rtl/ofifo_psum_lane.sv
// One FIFO lane: storage, write pointer and occupancy count.
// The read pointer is shared and owned by the top level, which only
// pops when every lane holds at least one entry.
module ofifo_lane
  import ofifo_psum_pkg::*;
#(
  parameter int bw_psum = PSUM_BW,
  parameter int depth   = DEPTH,
  localparam int aw     = $clog2(depth)
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [bw_psum-1:0] din,
  input  logic               wr,
  input  logic               pop,
  input  logic [aw-1:0]      rptr,
  output logic [bw_psum-1:0] dout,
  output logic               empty_n,
  output logic               full,
  output logic [aw:0]        count,
  output logic               drop
);

  localparam logic [aw:0] FULL_COUNT = (aw+1)'(depth);

  logic [bw_psum-1:0] mem [depth];
  logic [aw-1:0]      wptr;
  logic               accept;

  // Fullness is judged on the registered count, so a same-cycle pop
  // never makes room for a write.
  assign full    = (count == FULL_COUNT);
  assign empty_n = (count != '0);
  assign accept  = wr & ~full;
  assign drop    = wr & full;
  assign dout    = mem[rptr];

  // Storage is deliberately left unreset; stale entries are never
  // visible because the top masks the output while any lane is empty.
  always_ff @(posedge clk) begin
    if (accept) mem[wptr] <= din;
  end

  // Write pointer advance and occupancy tracking for push/pop combinations
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wptr  <= '0;
      count <= '0;
    end else begin
      if (accept) wptr <= wptr + 1'b1;
      case ({accept, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/ofifo_psum.sv
// Output FIFO behind the MAC column array. Each column fills its own
// lane independently; complete rows are popped in lockstep with a
// single shared read pointer. Dropped writes raise a sticky overflow.
module ofifo_psum
  import ofifo_psum_pkg::*;
#(
  parameter int col     = COL,
  parameter int bw_psum = PSUM_BW,
  parameter int depth   = DEPTH,
  localparam int aw     = $clog2(depth)
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [col*bw_psum-1:0] in,
  input  logic [col-1:0]         wr,
  input  logic                   rd,
  output logic [col*bw_psum-1:0] out,
  output logic                   o_valid,
  output logic                   o_full,
  output logic                   o_ready,
  output logic [aw:0]            row_count,
  output logic                   overflow,
  input  logic                   ovf_clr
);

  logic [aw-1:0]      rptr;
  logic               pop;
  logic [col-1:0]     lane_empty_n;
  logic [col-1:0]     lane_full;
  logic [col-1:0]     lane_drop;
  logic [aw:0]        lane_count [col];
  logic [bw_psum-1:0] lane_dout  [col];

  assign o_valid = &lane_empty_n;
  assign o_full  = |lane_full;
  assign o_ready = ~o_full;
  assign pop     = rd & o_valid;

  for (genvar i = 0; i < col; i++) begin : g_lane
    ofifo_lane #(
      .bw_psum (bw_psum),
      .depth   (depth)
    ) u_lane (
      .clk     (clk),
      .reset   (reset),
      .din     (in[lane_lsb(i, bw_psum) +: bw_psum]),
      .wr      (wr[i]),
      .pop     (pop),
      .rptr    (rptr),
      .dout    (lane_dout[i]),
      .empty_n (lane_empty_n[i]),
      .full    (lane_full[i]),
      .count   (lane_count[i]),
      .drop    (lane_drop[i])
    );

    assign out[lane_lsb(i, bw_psum) +: bw_psum] = o_valid ? lane_dout[i] : '0;
  end

  // Complete rows are limited by the emptiest lane
  always_comb begin
    row_count = lane_count[0];
    for (int i = 1; i < col; i++) begin
      if (lane_count[i] < row_count) row_count = lane_count[i];
    end
  end

  // Shared read pointer advances only on an accepted lockstep pop
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) rptr <= '0;
    else if (pop) rptr <= rptr + 1'b1;
  end

  // Sticky overflow; a drop in the same cycle as a clear wins
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)          overflow <= 1'b0;
    else if (|lane_drop) overflow <= 1'b1;
    else if (ovf_clr)    overflow <= 1'b0;
  end

endmodule

// File: tb/tb_ofifo_psum.sv
// Directed self-checking bench for ofifo_psum (8 lanes x 22 bits, depth 64).
module tb_ofifo_psum;

  localparam int W = 176;

  logic         clk;
  logic         reset;
  logic [W-1:0] in_bus;
  logic [7:0]   wr;
  logic         rd;
  logic [W-1:0] out_bus;
  logic         o_valid;
  logic         o_full;
  logic         o_ready;
  logic [6:0]   row_count;
  logic         overflow;
  logic         ovf_clr;

  int checks;
  int errors;

  ofifo_psum dut (
    .clk       (clk),
    .reset     (reset),
    .in        (in_bus),
    .wr        (wr),
    .rd        (rd),
    .out       (out_bus),
    .o_valid   (o_valid),
    .o_full    (o_full),
    .o_ready   (o_ready),
    .row_count (row_count),
    .overflow  (overflow),
    .ovf_clr   (ovf_clr)
  );

  // Free-running clock, 10 time-unit period
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Safety net so the run always terminates
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: observed timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  // Row whose lane i carries base+i
  function automatic logic [W-1:0] pack_row(input int base);
    logic [W-1:0] r;
    r = '0;
    for (int i = 0; i < 8; i++) r[i*22 +: 22] = 22'(base + i);
    return r;
  endfunction

  task automatic check_output(input string tag, input logic [W-1:0] observed,
                              input logic [W-1:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
    end
  endtask

  // Drive one cycle of inputs, clock it in, then return to idle 1 unit after the edge
  task automatic apply_stimulus(input logic [7:0] wr_v, input logic [W-1:0] data,
                                input logic rd_v, input logic clr_v);
    wr      = wr_v;
    in_bus  = data;
    rd      = rd_v;
    ovf_clr = clr_v;
    @(posedge clk);
    #1;
    wr      = '0;
    in_bus  = '0;
    rd      = 1'b0;
    ovf_clr = 1'b0;
  endtask

  task automatic reset_dut();
    reset = 1'b0;
    @(posedge clk);
    #1;
    reset = 1'b1;
  endtask

  initial begin
    checks  = 0;
    errors  = 0;
    reset   = 1'b0;
    wr      = '0;
    rd      = 1'b0;
    ovf_clr = 1'b0;
    in_bus  = '0;
    repeat (2) @(posedge clk);
    #1;

    // Reset state
    check_output("rst_valid", W'(o_valid), W'(0));
    check_output("rst_full", W'(o_full), W'(0));
    check_output("rst_ready", W'(o_ready), W'(1));
    check_output("rst_rowcnt", W'(row_count), W'(0));
    check_output("rst_out", out_bus, '0);
    check_output("rst_ovf", W'(overflow), W'(0));
    reset = 1'b1;

    // Reset in the middle of a fill
    for (int k = 0; k < 5; k++) apply_stimulus(8'hFF, pack_row(10*k), 1'b0, 1'b0);
    check_output("mid_rowcnt5", W'(row_count), W'(5));
    check_output("mid_head", out_bus, pack_row(0));
    reset = 1'b0;
    #2;
    check_output("mid_rst_valid", W'(o_valid), W'(0));
    check_output("mid_rst_rowcnt", W'(row_count), W'(0));
    check_output("mid_rst_out", out_bus, '0);
    @(posedge clk);
    #1;
    reset = 1'b1;
    apply_stimulus(8'hFF, pack_row(50), 1'b0, 1'b0);
    check_output("mid_rowcnt1", W'(row_count), W'(1));
    check_output("mid_new_head", out_bus, pack_row(50));

    // Staggered fill: lane i starts writing at step i
    reset_dut();
    for (int t = 0; t < 7; t++) apply_stimulus(8'((1 << (t+1)) - 1), pack_row(100), 1'b0, 1'b0);
    check_output("stag_valid_pre", W'(o_valid), W'(0));
    check_output("stag_rowcnt_pre", W'(row_count), W'(0));
    check_output("stag_out_pre", out_bus, '0);
    apply_stimulus(8'hFF, pack_row(100), 1'b0, 1'b0);
    check_output("stag_valid", W'(o_valid), W'(1));
    check_output("stag_head", out_bus, pack_row(100));
    check_output("stag_rowcnt1", W'(row_count), W'(1));
    repeat (7) apply_stimulus(8'hFF, pack_row(100), 1'b0, 1'b0);
    check_output("stag_rowcnt8", W'(row_count), W'(8));
    check_output("stag_full", W'(o_full), W'(0));

    // Lockstep drain of three rows, then two extra pops
    reset_dut();
    for (int r = 1; r <= 3; r++) apply_stimulus(8'hFF, pack_row(r*10), 1'b0, 1'b0);
    check_output("drain_head", out_bus, pack_row(10));
    check_output("drain_rowcnt", W'(row_count), W'(3));
    for (int p = 0; p < 5; p++) begin
      apply_stimulus(8'h00, '0, 1'b1, 1'b0);
      check_output("drain_out", out_bus, (p < 2) ? pack_row((p+2)*10) : '0);
      check_output("drain_rowcnt_p", W'(row_count), W'((p < 2) ? (2 - p) : 0));
    end
    check_output("drain_valid", W'(o_valid), W'(0));
    check_output("drain_ovf", W'(overflow), W'(0));

    // Full, dropped write with pop, sticky flag and clear priority
    reset_dut();
    for (int k = 0; k < 64; k++) apply_stimulus(8'hFF, pack_row(k), 1'b0, 1'b0);
    check_output("full_flag", W'(o_full), W'(1));
    check_output("full_ready", W'(o_ready), W'(0));
    check_output("full_rowcnt", W'(row_count), W'(64));
    check_output("full_ovf0", W'(overflow), W'(0));
    check_output("full_head", out_bus, pack_row(0));
    apply_stimulus(8'hFF, pack_row(999), 1'b1, 1'b0);
    check_output("drop_rowcnt", W'(row_count), W'(63));
    check_output("drop_ovf", W'(overflow), W'(1));
    check_output("drop_head", out_bus, pack_row(1));
    check_output("drop_full", W'(o_full), W'(0));
    apply_stimulus(8'h00, '0, 1'b0, 1'b1);
    check_output("clr_ovf", W'(overflow), W'(0));
    apply_stimulus(8'hFF, pack_row(64), 1'b0, 1'b0);
    check_output("refill_full", W'(o_full), W'(1));
    apply_stimulus(8'hFF, pack_row(777), 1'b0, 1'b1);
    check_output("set_beats_clr", W'(overflow), W'(1));
    check_output("drop2_rowcnt", W'(row_count), W'(64));
    apply_stimulus(8'h00, '0, 1'b0, 1'b1);
    check_output("clr2_ovf", W'(overflow), W'(0));
    repeat (63) apply_stimulus(8'h00, '0, 1'b1, 1'b0);
    check_output("tail_head", out_bus, pack_row(64));
    check_output("tail_rowcnt", W'(row_count), W'(1));

    // Simultaneous pop and write with two rows held
    reset_dut();
    apply_stimulus(8'hFF, pack_row(500), 1'b0, 1'b0);
    apply_stimulus(8'hFF, pack_row(600), 1'b0, 1'b0);
    check_output("sim_rowcnt2", W'(row_count), W'(2));
    apply_stimulus(8'hFF, pack_row(700), 1'b1, 1'b0);
    check_output("sim_rowcnt_keep", W'(row_count), W'(2));
    check_output("sim_head", out_bus, pack_row(600));
    apply_stimulus(8'h00, '0, 1'b1, 1'b0);
    check_output("sim_next", out_bus, pack_row(700));
    check_output("sim_rowcnt1", W'(row_count), W'(1));
    apply_stimulus(8'h00, '0, 1'b1, 1'b0);
    check_output("sim_empty", W'(o_valid), W'(0));

    // Pointer wrap: 200 write/pop pairs crossing 64, 128 and 192
    reset_dut();
    for (int k = 0; k < 200; k++) begin
      apply_stimulus(8'hFF, pack_row(k), 1'b0, 1'b0);
      check_output("wrap_out", out_bus, pack_row(k));
      apply_stimulus(8'h00, '0, 1'b1, 1'b0);
    end
    check_output("wrap_empty", W'(o_valid), W'(0));
    check_output("wrap_ovf", W'(overflow), W'(0));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
